// File: rtl/uart_rx.sv
// 8N1 UART receiver with OSR-times oversampling on an external CLK_EN tick.
// Optional 2-of-3 majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx #(
  parameter int OSR = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLK_EN,
  input  logic       RX_IN,
  input  logic       RDY_CLR,
  output logic [7:0] DOUT,
  output logic       RDY,
  output logic       RX_BUSY,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [3:0] HALF_LAST = 4'(OSR / 2 - 1);
  localparam logic [3:0] BIT_LAST  = 4'(OSR - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [2:0] pos_reg, pos_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] dout_reg, dout_next;
  logic       rdy_reg, rdy_next;
  logic       ferr_reg, ferr_next;
  logic       ovr_reg, ovr_next;
  logic       armed_reg, armed_next;
  logic [1:0] sync_reg;
  logic       rx;
  logic       bit_sample;
  logic       byte_done;

  // Two-flop synchronizer, idles high so reset does not look like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], RX_IN};
  end

  assign rx = sync_reg[1];

`ifdef UART_RX_MAJORITY_EN
  // rx at the two ticks preceding the current one; vote over target-2..target.
  logic [1:0] hist_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         hist_reg <= 2'b11;
    else if (CLK_EN) hist_reg <= {hist_reg[0], rx};
  end

  assign bit_sample = (hist_reg[0] & hist_reg[1]) | (hist_reg[0] & rx) | (hist_reg[1] & rx);
`else
  assign bit_sample = rx;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      pos_reg   <= 3'd0;
      shift_reg <= 8'h00;
      dout_reg  <= 8'h00;
      rdy_reg   <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pos_reg   <= pos_next;
      shift_reg <= shift_next;
      dout_reg  <= dout_next;
      rdy_reg   <= rdy_next;
      ferr_reg  <= ferr_next;
      ovr_reg   <= ovr_next;
      armed_reg <= armed_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pos_next   = pos_reg;
    shift_next = shift_reg;
    dout_next  = dout_reg;
    rdy_next   = rdy_reg;
    ferr_next  = ferr_reg;
    ovr_next   = ovr_reg;
    armed_next = armed_reg;
    byte_done  = 1'b0;

    if (CLK_EN) begin
      case (state_reg)
        IDLE: begin
          // A line that never went high (e.g. after a framing error) cannot start a frame.
          if (rx) armed_next = 1'b1;
          if (!rx && armed_reg) begin
            state_next = START;
            cnt_next   = 4'd0;
            pos_next   = 3'd0;
          end
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_next   = 4'd0;
            state_next = bit_sample ? IDLE : DATA;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_next            = 4'd0;
            shift_next[pos_reg] = bit_sample;
            if (pos_reg == 3'd7) state_next = STOP;
            else                 pos_next   = pos_reg + 3'd1;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_next   = 4'd0;
            state_next = IDLE;
            if (bit_sample) begin
              byte_done = 1'b1;
            end else begin
              ferr_next  = 1'b1;
              armed_next = 1'b0;
            end
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (RDY_CLR) begin
      rdy_next = 1'b0;
      ovr_next = 1'b0;
    end
    // A completing byte takes priority over a same-cycle acknowledge.
    if (byte_done) begin
      dout_next = shift_reg;
      rdy_next  = 1'b1;
      ferr_next = 1'b0;
      if (rdy_reg) ovr_next = 1'b1;
    end
  end

  assign DOUT      = dout_reg;
  assign RDY       = rdy_reg;
  assign FRAME_ERR = ferr_reg;
  assign OVERRUN   = ovr_reg;
  assign RX_BUSY   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (OSR=16): table of frames plus hand-written
// sequences for glitches, framing errors, reset, acknowledge and tick gating.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CLK_EN;
  logic       RX_IN;
  logic       RDY_CLR;
  logic [7:0] DOUT;
  logic       RDY;
  logic       RX_BUSY;
  logic       FRAME_ERR;
  logic       OVERRUN;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  uart_rx #(.OSR(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CLK_EN    (CLK_EN),
    .RX_IN     (RX_IN),
    .RDY_CLR   (RDY_CLR),
    .DOUT      (DOUT),
    .RDY       (RDY),
    .RX_BUSY   (RX_BUSY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN)
  );

  typedef struct {
    logic       clr;
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_rdy;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_clr();
    RDY_CLR = 1'b1;
    cycles(1);
    RDY_CLR = 1'b0;
    cycles(1);
  endtask

  // One tick per cycle: frame tick j is driven just after edge k+j.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_j,
                            input int clr_j, input int nticks, input logic tail);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    @(posedge CLK);
    #1;
    for (int j = 0; j < nticks; j++) begin
      RX_IN = frame[j / 16];
      if (j == glitch_j) RX_IN = ~RX_IN;
      RDY_CLR = (j == clr_j);
      @(posedge CLK);
      #1;
    end
    RX_IN   = tail;
    RDY_CLR = 1'b0;
  endtask

  logic [7:0] exp_glitch;
  logic       saw_busy;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h3C, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'h00;
`else
    exp_glitch = 8'h08;
`endif

    RST = 1'b1; CLK_EN = 1'b1; RX_IN = 1'b1; RDY_CLR = 1'b0;
    cycles(3);
    @(negedge CLK);
    check8("reset_dout", DOUT, 8'h00);
    check1("reset_rdy", RDY, 1'b0);
    check1("reset_ferr", FRAME_ERR, 1'b0);
    check1("reset_ovr", OVERRUN, 1'b0);
    check1("reset_busy", RX_BUSY, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cycles(20);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr) begin
        pulse_clr();
        @(negedge CLK);
        check1("clr_rdy", RDY, 1'b0);
        check1("clr_ovr", OVERRUN, 1'b0);
      end
      send_frame(vecs[i].data, vecs[i].stop, -1, -1, 160, 1'b1);
      cycles(20);
      @(negedge CLK);
      $display("[TB] vec %0d: data=%02h stop=%b -> DOUT=%02h RDY=%b FERR=%b OVR=%b BUSY=%b",
               i, vecs[i].data, vecs[i].stop, DOUT, RDY, FRAME_ERR, OVERRUN, RX_BUSY);
      check8("vec_dout", DOUT, vecs[i].exp_dout);
      check1("vec_rdy", RDY, vecs[i].exp_rdy);
      check1("vec_ferr", FRAME_ERR, vecs[i].exp_ferr);
      check1("vec_ovr", OVERRUN, vecs[i].exp_ovr);
      check1("vec_busy", RX_BUSY, 1'b0);
    end

    // Short low pulse: START entered, then rejected at mid-bit.
    pulse_clr();
    RX_IN = 1'b0;
    cycles(3);
    @(negedge CLK);
    check1("glitch_busy", RX_BUSY, 1'b1);
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    cycles(20);
    @(negedge CLK);
    $display("[TB] start glitch -> DOUT=%02h RDY=%b BUSY=%b", DOUT, RDY, RX_BUSY);
    check1("glitch_idle", RX_BUSY, 1'b0);
    check1("glitch_rdy", RDY, 1'b0);
    check8("glitch_dout", DOUT, 8'hC3);
    check1("glitch_ferr", FRAME_ERR, 1'b0);

    // Framing error followed by a line stuck low: must not re-trigger.
    send_frame(8'h3C, 1'b0, -1, -1, 160, 1'b0);
    saw_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (RX_BUSY) saw_busy = 1'b1;
    end
    $display("[TB] 3C stop=0, line low -> DOUT=%02h RDY=%b FERR=%b", DOUT, RDY, FRAME_ERR);
    check1("ferr_set", FRAME_ERR, 1'b1);
    check1("ferr_rdy", RDY, 1'b0);
    check8("ferr_dout", DOUT, 8'hC3);
    check1("ferr_no_restart", saw_busy, 1'b0);
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    cycles(20);
    send_frame(8'h69, 1'b1, -1, -1, 160, 1'b1);
    cycles(20);
    @(negedge CLK);
    $display("[TB] 69 after rearm -> DOUT=%02h RDY=%b FERR=%b", DOUT, RDY, FRAME_ERR);
    check8("rearm_dout", DOUT, 8'h69);
    check1("rearm_rdy", RDY, 1'b1);
    check1("rearm_ferr", FRAME_ERR, 1'b0);

    // Reset in the middle of a data phase.
    send_frame(8'hFF, 1'b1, -1, -1, 60, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    $display("[TB] reset mid-frame -> DOUT=%02h RDY=%b BUSY=%b", DOUT, RDY, RX_BUSY);
    check8("mid_rst_dout", DOUT, 8'h00);
    check1("mid_rst_rdy", RDY, 1'b0);
    check1("mid_rst_ferr", FRAME_ERR, 1'b0);
    check1("mid_rst_ovr", OVERRUN, 1'b0);
    check1("mid_rst_busy", RX_BUSY, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cycles(20);
    send_frame(8'h5A, 1'b1, -1, -1, 160, 1'b1);
    cycles(20);
    @(negedge CLK);
    $display("[TB] 5A after reset -> DOUT=%02h RDY=%b OVR=%b", DOUT, RDY, OVERRUN);
    check8("post_rst_dout", DOUT, 8'h5A);
    check1("post_rst_rdy", RDY, 1'b1);
    check1("post_rst_ovr", OVERRUN, 1'b0);

    // Single-tick high glitch on the bit-3 target tick of 0x00.
    pulse_clr();
    send_frame(8'h00, 1'b1, 72, -1, 160, 1'b1);
    cycles(20);
    @(negedge CLK);
    $display("[TB] 00 with bit3 glitch -> DOUT=%02h RDY=%b", DOUT, RDY);
    check8("vote_dout", DOUT, exp_glitch);
    check1("vote_rdy", RDY, 1'b1);

    // Acknowledge lands on the completion cycle: new byte wins.
    send_frame(8'h96, 1'b1, -1, 154, 160, 1'b1);
    cycles(20);
    @(negedge CLK);
    $display("[TB] 96 with coincident RDY_CLR -> DOUT=%02h RDY=%b", DOUT, RDY);
    check8("setwin_dout", DOUT, 8'h96);
    check1("setwin_rdy", RDY, 1'b1);

    // Acknowledge with nothing pending.
    pulse_clr();
    pulse_clr();
    @(negedge CLK);
    $display("[TB] double RDY_CLR -> DOUT=%02h RDY=%b OVR=%b", DOUT, RDY, OVERRUN);
    check1("idle_clr_rdy", RDY, 1'b0);
    check1("idle_clr_ovr", OVERRUN, 1'b0);
    check8("idle_clr_dout", DOUT, 8'h96);

    // Nothing advances without CLK_EN.
    CLK_EN = 1'b0;
    RX_IN  = 1'b0;
    cycles(30);
    @(negedge CLK);
    check1("gate_idle_hold", RX_BUSY, 1'b0);
    @(posedge CLK);
    #1;
    CLK_EN = 1'b1;
    cycles(1);
    CLK_EN = 1'b0;
    @(negedge CLK);
    check1("gate_one_tick", RX_BUSY, 1'b1);
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    cycles(30);
    @(negedge CLK);
    check1("gate_start_hold", RX_BUSY, 1'b1);
    @(posedge CLK);
    #1;
    CLK_EN = 1'b1;
    cycles(20);
    @(negedge CLK);
    $display("[TB] CLK_EN gating -> BUSY=%b RDY=%b DOUT=%02h", RX_BUSY, RDY, DOUT);
    check1("gate_resume", RX_BUSY, 1'b0);
    check1("gate_rdy", RDY, 1'b0);
    check8("gate_dout", DOUT, 8'h96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
